// File: rtl/hpdmc_ctlif_seq.sv
// hpdmc_ctlif_seq
// CSR control interface for the HPDMC SDRAM controller. Holds the SDRAM mode
// bits, timing parameters and IDELAY control. In bypass mode it issues
// software SDRAM commands, followed by a hardware post-command wait counter.
// It can send repeated IDELAY tap pulses and reports busy/overrun status.
//
// Ports
//   sys_clk, sys_rst          clock and synchronous active-high reset
//   csr_a, csr_we, csr_di     CSR bus: [13:10] page, [2:0] register
//   csr_do                    registered read data, 1-cycle latency
//   bypass, sdram_rst,        mode control
//   sdram_cke
//   sdram_cs_n/we_n/          software command pins, active low,
//   cas_n/ras_n               one-cycle pulses
//   sdram_adr, sdram_ba       address and bank for software commands
//   tim_rp .. tim_wr          timing parameters for the controller
//   idelay_rst/ce/inc/cal     IDELAY tap control
//
// Register map (on the selected page)
//   0 CTRL rw   [0] bypass  [1] sdram_rst  [2] cke
//   1 CMD  wo   [3:0] {ras,cas,we,cs}  [4+:ADR_W] adr  next BA_W bits: ba
//               [31:24] WAIT.  Reads back {WAIT remaining, ba, adr, 4'h0}.
//   2 TIM  rw   LSB first {wr,rfc,refi,cas,rcd,rp}
//   3 IDLY wo   [0] rst  [1] ce  [2] inc  [3] cal  [15:8] pulse count N
//   4 STAT ro   [0] cmd_busy  [1] idly_busy  [2] overrun (write 1 to clear)
module hpdmc_ctlif_seq #(
  parameter logic [3:0] csr_addr = 4'h0,
  parameter int ADR_W    = 13,
  parameter int BA_W     = 2,
  parameter int REFI_W   = 11,
  parameter int REFI_RST = 620
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [13:0]       csr_a,
  input  logic              csr_we,
  input  logic [31:0]       csr_di,
  output logic [31:0]       csr_do,
  output logic              bypass,
  output logic              sdram_rst,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_we_n,
  output logic              sdram_cas_n,
  output logic              sdram_ras_n,
  output logic [ADR_W-1:0]  sdram_adr,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [2:0]        tim_rp,
  output logic [2:0]        tim_rcd,
  output logic              tim_cas,
  output logic [REFI_W-1:0] tim_refi,
  output logic [3:0]        tim_rfc,
  output logic [1:0]        tim_wr,
  output logic              idelay_rst,
  output logic              idelay_ce,
  output logic              idelay_inc,
  output logic              idelay_cal
);

  // Decrement that stops at zero instead of wrapping.
  function automatic logic [7:0] sat_dec(input logic [7:0] x);
    return (x == 8'd0) ? 8'd0 : x - 8'd1;
  endfunction

  // Timing register image, packed LSB first; unused MSBs read as zero.
  function automatic logic [31:0] pack_tim(
    input logic [2:0]        rp,
    input logic [2:0]        rcd,
    input logic              cas,
    input logic [REFI_W-1:0] refi,
    input logic [3:0]        rfc,
    input logic [1:0]        wr
  );
    logic [31:0] t;
    t                    = '0;
    t[2:0]               = rp;
    t[5:3]               = rcd;
    t[6]                 = cas;
    t[7 +: REFI_W]       = refi;
    t[7 + REFI_W +: 4]   = rfc;
    t[11 + REFI_W +: 2]  = wr;
    return t;
  endfunction

  logic        csr_selected;
  logic        wr_ctrl, wr_cmd, wr_tim, wr_idly, wr_stat;
  logic        cmd_pulse;      // command pins are low this cycle
  logic [7:0]  cmd_wait;       // post-command wait cycles remaining
  logic        cmd_busy;
  logic        cmd_accept, cmd_drop;
  logic [7:0]  idly_rem;       // ce pulses still to issue after the current one
  logic        idly_busy;
  logic        idly_accept, idly_drop;
  logic        overrun;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign csr_selected = (csr_a[13:10] == csr_addr);
  assign wr_ctrl = csr_selected & csr_we & (csr_a[2:0] == 3'd0);
  assign wr_cmd  = csr_selected & csr_we & (csr_a[2:0] == 3'd1);
  assign wr_tim  = csr_selected & csr_we & (csr_a[2:0] == 3'd2);
  assign wr_idly = csr_selected & csr_we & (csr_a[2:0] == 3'd3);
  assign wr_stat = csr_selected & csr_we & (csr_a[2:0] == 3'd4);

  // The pulse cycle itself counts as busy, so WAIT=0 still blocks that cycle.
  assign cmd_busy   = cmd_pulse | (cmd_wait != 8'd0);
  assign cmd_accept = wr_cmd & ~cmd_busy;
  assign cmd_drop   = wr_cmd &  cmd_busy;

  assign idly_busy   = idelay_ce | (idly_rem != 8'd0);
  assign idly_accept = wr_idly & csr_di[1] & ~idly_busy;
  assign idly_drop   = wr_idly & csr_di[1] &  idly_busy;

  assign unused_bits = ^{csr_a[9:3], csr_di};

  always_comb begin
    rd_data = '0;
    case (csr_a[2:0])
      3'd0: rd_data[2:0] = {sdram_cke, sdram_rst, bypass};
      3'd1: begin
        rd_data[4 +: ADR_W]        = sdram_adr;
        rd_data[4 + ADR_W +: BA_W] = sdram_ba;
        rd_data[31:24]             = cmd_wait;
      end
      3'd2: rd_data = pack_tim(tim_rp, tim_rcd, tim_cas, tim_refi, tim_rfc, tim_wr);
      3'd4: rd_data[2:0] = {overrun, idly_busy, cmd_busy};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      csr_do      <= '0;
      bypass      <= 1'b1;
      sdram_rst   <= 1'b1;
      sdram_cke   <= 1'b0;
      sdram_cs_n  <= 1'b1;
      sdram_we_n  <= 1'b1;
      sdram_cas_n <= 1'b1;
      sdram_ras_n <= 1'b1;
      sdram_adr   <= '0;
      sdram_ba    <= '0;
      tim_rp      <= 3'd2;
      tim_rcd     <= 3'd2;
      tim_cas     <= 1'b0;
      tim_refi    <= REFI_W'(REFI_RST);
      tim_rfc     <= 4'd6;
      tim_wr      <= 2'd2;
      idelay_rst  <= 1'b0;
      idelay_ce   <= 1'b0;
      idelay_inc  <= 1'b0;
      idelay_cal  <= 1'b0;
      cmd_pulse   <= 1'b0;
      cmd_wait    <= '0;
      idly_rem    <= '0;
      overrun     <= 1'b0;
    end else begin
      csr_do <= csr_selected ? rd_data : 32'd0;

      if (wr_ctrl) begin
        bypass    <= csr_di[0];
        sdram_rst <= csr_di[1];
        sdram_cke <= csr_di[2];
      end

      if (wr_tim) begin
        tim_rp   <= csr_di[2:0];
        tim_rcd  <= csr_di[5:3];
        tim_cas  <= csr_di[6];
        tim_refi <= csr_di[7 +: REFI_W];
        tim_rfc  <= csr_di[7 + REFI_W +: 4];
        tim_wr   <= csr_di[11 + REFI_W +: 2];
      end

      // Command pins idle high unless a write was accepted on the previous
      // cycle; a write is accepted only when idle, so one write -> one pulse.
      sdram_cs_n  <= 1'b1;
      sdram_we_n  <= 1'b1;
      sdram_cas_n <= 1'b1;
      sdram_ras_n <= 1'b1;
      if (cmd_accept) begin
        sdram_cs_n  <= ~csr_di[0];
        sdram_we_n  <= ~csr_di[1];
        sdram_cas_n <= ~csr_di[2];
        sdram_ras_n <= ~csr_di[3];
        sdram_adr   <= csr_di[4 +: ADR_W];
        sdram_ba    <= csr_di[4 + ADR_W +: BA_W];
        cmd_pulse   <= 1'b1;
        cmd_wait    <= csr_di[31:24];
      end else begin
        cmd_pulse <= 1'b0;
        // Wait countdown starts only once the pulse cycle is over.
        if (!cmd_pulse)
          cmd_wait <= sat_dec(cmd_wait);
      end

      idelay_rst <= wr_idly & csr_di[0];
      if (wr_idly)
        idelay_cal <= csr_di[3];

      // Pulse train: ce high, one idle cycle, ce high ... until idly_rem is 0.
      if (idly_accept) begin
        idelay_ce  <= 1'b1;
        idelay_inc <= csr_di[2];
        idly_rem   <= sat_dec(csr_di[15:8]);
      end else if (idelay_ce) begin
        idelay_ce <= 1'b0;
      end else if (idly_rem != 8'd0) begin
        idelay_ce <= 1'b1;
        idly_rem  <= sat_dec(idly_rem);
      end

      // Set has priority over the software clear.
      if (cmd_drop | idly_drop)
        overrun <= 1'b1;
      else if (wr_stat & csr_di[2])
        overrun <= 1'b0;
    end
  end

endmodule
